hazard_scoreboard_unit: RTL
===========================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised hazard unit for the 5-stage RISC-V pipeline.
//  - Load-use stall, branch/jump flush, E-stage operand forwarding with correct M-over-W priority.
//  - Adds a register scoreboard for a fixed-latency multi-cycle mul/div unit issued from E,
//    with stalls on reads of pending destinations and on back-to-back md issue.
// PARAMETERS
//  REG_COUNT  32  architectural registers; x0 is hard zero
//  ADDR_W     5   register index width, $clog2(REG_COUNT)
//  MD_LAT     4   md cycles from E issue to result; legal range >=2
//  PERF_W     16  perf counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  rs1D,rs2D    in   ADDR_W  D-stage source indices
//  mdOpD        in   1       D-stage instruction is mul/div
//  rs1E,rs2E    in   ADDR_W  E-stage source indices
//  rdE          in   ADDR_W  E-stage destination
//  loadE        in   1       E-stage instruction is a load (resultSrc0)
//  mdStartE     in   1       E-stage mul/div issues this cycle
//  pcSrcE       in   2       !=0: taken branch/jump in E
//  rdM,rdW      in   ADDR_W  M/W destinations
//  regWriteM/W  in   1       M/W write enables
//  luiM         in   1       M-stage instruction is LUI
//  forwardAE/BE out  2       00 regfile, 01 W result, 10 M ALU, 11 M immediate
//  stallF,stallD out 1       hold PC / IF-ID
//  flushD,flushE out 1       bubble IF-ID / ID-EX
//  mdBusy       out  1       md counter nonzero
//  mdWbW        out  1       one-cycle pulse: md result writes mdRdW this cycle
//  mdRdW        out  ADDR_W  md destination being written back
// BEHAVIOUR
//  - Reset: scoreboard cleared, counter=0, mdRdW=0; all outputs 0.
//  - Forwarding is combinational; index 0 always gives 00.
//    Select 10, or 11 when luiM, if rsE==rdM && regWriteM; else 01 if rsE==rdW && regWriteW; else 00.
//  - lwStall = loadE && rdE!=0 && (rs1D==rdE || rs2D==rdE).
//  - sbStall = scoreboard bit set for a nonzero rs1D/rs2D, or mdOpD && mdBusy && counter>1.
//  - stall = lwStall | sbStall. stallF=stallD=stall && pcSrcE==0.
//    flushD = pcSrcE!=0. flushE = stall | pcSrcE!=0.
//  - Flush dominates stall: wrong-path D instruction is discarded, never held.
//  - md issue (mdStartE && rdE!=0), registered: counter<=MD_LAT, sb[rdE]<=1, mdRdW<=rdE.
//    E is live this cycle, so issue happens even if flushE is asserted.
//  - md issue with rdE==0: counter loads, no scoreboard bit, mdWbW still pulses.
//  - Each cycle counter>0: decrement. Counter==1: mdWbW=1 and sb[mdRdW] cleared on that edge.
//  - Same-edge completion clear and new issue set to the same register: set wins.
//  - Issue on the completion cycle is legal: counter reloads and busy continues seamlessly.
//  - mdStartE while counter>1 is a protocol error; assertion fires in simulation.
//  - rst mid-operation: counter, scoreboard and mdRdW cleared; no mdWbW pulse is emitted.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - Adds outputs stallCnt, flushCnt, mdStallCnt [PERF_W-1:0], saturating, cleared on rst.
//   - stallCnt increments per cycle stallF=1; flushCnt per cycle flushD=1;
//     mdStallCnt per cycle sbStall && stallF.
//  Undefined: ports and counters absent; logic otherwise identical.
// STRUCTURE
//  - hazard_pkg: FWD_REG/FWD_W/FWD_M_ALU/FWD_M_IMM 2-bit constants, PCSRC_SEQ=2'b00.
//  - Sub-module md_scoreboard: counter, REG_COUNT-bit busy vector, mdRdW, mdWbW.
//    Exposes a busy-lookup for rs1D/rs2D. The top holds forwarding and stall/flush logic.
// TESTING
//  - rs1E=5,rdM=5,regWriteM=1,rdW=5,regWriteW=1 -> forwardAE=10; with luiM=1 -> 11.
//    With rs1E=0 -> 00.
//  - loadE=1,rdE=7,rs2D=7 -> stallF=stallD=flushE=1 for 1 cycle.
//    Same stimulus with pcSrcE=01 -> stallF=stallD=0, flushD=flushE=1.
//  - mdStartE,rdE=9, MD_LAT=4; next cycle rs1D=9 -> stall 3 cycles, mdWbW with mdRdW=9
//    on 4th cycle, stall drops the same cycle.
//  - md issue rdE=3; mdOpD held -> stall until counter==1; 2nd issue on completion cycle
//    -> mdBusy stays 1, sb[3] remains set.
//  - md issue, rst at counter==2 -> mdBusy=0, no mdWbW, rs1D=issued reg does not stall.
//  - HAZARD_PERF_CNT_EN, PERF_W=4: hold stall 20 cycles -> stallCnt saturates at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and the forwarding-select helper for the hazard scoreboard unit.
// Optional perf counters in the top are enabled by defining HAZARD_PERF_CNT_EN.
`timescale 1ns/1ps
package hazard_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_W     = 2'b01;
   localparam logic [1:0] FWD_M_ALU = 2'b10;
   localparam logic [1:0] FWD_M_IMM = 2'b11;
   localparam logic [1:0] PCSRC_SEQ = 2'b00;

   // M beats W because M holds the younger result; LUI in M forwards its immediate path.
   function automatic logic [1:0] fwd_select(
      input logic src_nonzero,
      input logic match_m,
      input logic reg_write_m,
      input logic lui_m,
      input logic match_w,
      input logic reg_write_w
   );
      logic [1:0] sel;
      sel = FWD_REG;
      if (!src_nonzero) begin
         sel = FWD_REG;
      end else if (match_m && reg_write_m) begin
         sel = lui_m ? FWD_M_IMM : FWD_M_ALU;
      end else if (match_w && reg_write_w) begin
         sel = FWD_W;
      end else begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_md_scoreboard.sv
// Fixed-latency mul/div tracker: countdown, per-register pending bits, writeback pulse.
// Also holds the protocol checker flagging an md issue while a previous one is mid-flight.
`timescale 1ns/1ps
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int MD_LAT    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              md_start,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              rs1_pending,
   output logic              rs2_pending,
   output logic              md_busy,
   output logic              cnt_gt_one,
   output logic              md_wb,
   output logic [ADDR_W-1:0] md_rd
);

   localparam int CNT_W = $clog2(MD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [ADDR_W-1:0] REG_X0  = {ADDR_W{1'b0}};

   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_next_s;
   logic [REG_COUNT-1:0] sb_r;
   logic [REG_COUNT-1:0] sb_next_s;
   logic [ADDR_W-1:0]    md_rd_r;
   logic [ADDR_W-1:0]    md_rd_next_s;
   logic                 wb_now_s;

   assign wb_now_s = (cnt_r == CNT_ONE) && !rst;

   // Next state; the issue set is applied after the completion clear so set wins.
   always_comb begin
      cnt_next_s   = cnt_r;
      sb_next_s    = sb_r;
      md_rd_next_s = md_rd_r;
      if (wb_now_s) begin
         sb_next_s[md_rd_r] = 1'b0;
      end else begin
         sb_next_s = sb_r;
      end
      if (md_start) begin
         cnt_next_s   = CNT_LOAD;
         md_rd_next_s = issue_rd;
         if (issue_rd != REG_X0) begin
            sb_next_s[issue_rd] = 1'b1;
         end else begin
            sb_next_s = sb_next_s;
         end
      end else if (cnt_r != CNT_ZERO) begin
         cnt_next_s = cnt_r - CNT_ONE;
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= CNT_ZERO;
         sb_r    <= {REG_COUNT{1'b0}};
         md_rd_r <= REG_X0;
      end else begin
         cnt_r   <= cnt_next_s;
         sb_r    <= sb_next_s;
         md_rd_r <= md_rd_next_s;
      end
   end

   // A register completing this cycle is already on the writeback path, so it no longer blocks.
   assign rs1_pending = (rs1 != REG_X0) && sb_r[rs1] && !(wb_now_s && (md_rd_r == rs1));
   assign rs2_pending = (rs2 != REG_X0) && sb_r[rs2] && !(wb_now_s && (md_rd_r == rs2));
   assign md_busy     = (cnt_r != CNT_ZERO);
   assign cnt_gt_one  = (cnt_r > CNT_ONE);
   assign md_wb       = wb_now_s;
   assign md_rd       = md_rd_r;

   md_scoreboard_checker u_checker (
      .clk        (clk),
      .rst        (rst),
      .md_start   (md_start),
      .cnt_gt_one (cnt_gt_one)
   );

endmodule

module md_scoreboard_checker (
   input logic clk,
   input logic rst,
   input logic md_start,
   input logic cnt_gt_one
);

   a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst) !(md_start && cnt_gt_one));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use and md-scoreboard stalls, flushes.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/md-stall counters.
`timescale 1ns/1ps
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int MD_LAT    = 4,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1D,
   input  logic [ADDR_W-1:0] rs2D,
   input  logic              mdOpD,
   input  logic [ADDR_W-1:0] rs1E,
   input  logic [ADDR_W-1:0] rs2E,
   input  logic [ADDR_W-1:0] rdE,
   input  logic              loadE,
   input  logic              mdStartE,
   input  logic [1:0]        pcSrcE,
   input  logic [ADDR_W-1:0] rdM,
   input  logic [ADDR_W-1:0] rdW,
   input  logic              regWriteM,
   input  logic              regWriteW,
   input  logic              luiM,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE,
   output logic              stallF,
   output logic              stallD,
   output logic              flushD,
   output logic              flushE,
   output logic              mdBusy,
   output logic              mdWbW,
   output logic [ADDR_W-1:0] mdRdW
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stallCnt,
   output logic [PERF_W-1:0] flushCnt,
   output logic [PERF_W-1:0] mdStallCnt
`endif
);

   localparam logic [ADDR_W-1:0] REG_X0 = {ADDR_W{1'b0}};

   logic rs1_pending_s;
   logic rs2_pending_s;
   logic cnt_gt_one_s;
   logic lw_stall_s;
   logic sb_stall_s;
   logic stall_s;
   logic redirect_s;

   md_scoreboard #(
      .REG_COUNT (REG_COUNT),
      .ADDR_W    (ADDR_W),
      .MD_LAT    (MD_LAT)
   ) u_md_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .md_start    (mdStartE),
      .issue_rd    (rdE),
      .rs1         (rs1D),
      .rs2         (rs2D),
      .rs1_pending (rs1_pending_s),
      .rs2_pending (rs2_pending_s),
      .md_busy     (mdBusy),
      .cnt_gt_one  (cnt_gt_one_s),
      .md_wb       (mdWbW),
      .md_rd       (mdRdW)
   );

   // Forwarding selects for both E-stage operands.
   always_comb begin
      forwardAE = fwd_select(rs1E != REG_X0, rs1E == rdM, regWriteM, luiM, rs1E == rdW, regWriteW);
      forwardBE = fwd_select(rs2E != REG_X0, rs2E == rdM, regWriteM, luiM, rs2E == rdW, regWriteW);
   end

   assign lw_stall_s = loadE && (rdE != REG_X0) && ((rs1D == rdE) || (rs2D == rdE));
   assign sb_stall_s = rs1_pending_s || rs2_pending_s || (mdOpD && mdBusy && cnt_gt_one_s);
   assign stall_s    = lw_stall_s || sb_stall_s;
   assign redirect_s = (pcSrcE != PCSRC_SEQ);

   // A redirect discards the wrong-path D instruction, so it overrides any hold.
   always_comb begin
      stallF = stall_s && !redirect_s;
      stallD = stall_s && !redirect_s;
      flushD = redirect_s;
      flushE = stall_s || redirect_s;
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
   localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt   <= {PERF_W{1'b0}};
         flushCnt   <= {PERF_W{1'b0}};
         mdStallCnt <= {PERF_W{1'b0}};
      end else begin
         if (stallF && (stallCnt != PERF_MAX)) begin
            stallCnt <= stallCnt + PERF_ONE;
         end
         if (flushD && (flushCnt != PERF_MAX)) begin
            flushCnt <= flushCnt + PERF_ONE;
         end
         if (sb_stall_s && stallF && (mdStallCnt != PERF_MAX)) begin
            mdStallCnt <= mdStallCnt + PERF_ONE;
         end
      end
   end
`endif

endmodule
